// File: rtl/udsp_pkg.sv
// Shared types and default widths for the uDSP frame sequencer and its write-port mux.
package udsp_pkg;

    localparam int DAW_DEF        = 10;
    localparam int DWW_DEF        = 36;
    localparam int IAW_DEF        = 9;
    // Cycles from the last fetch until the final writeback lands; tracks the uDSP pipeline depth.
    localparam int UDSP_DRAIN_CYC = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_e;

endpackage

// File: rtl/udsp_wport_mux.sv
// Data-RAM write-port mux: host writes only while idle and no tick is pending,
// uDSP writeback otherwise. A uDSP write enable seen while idle is dropped.
module udsp_wport_mux
    import udsp_pkg::*;
#(
    parameter int DAW = DAW_DEF,
    parameter int DWW = DWW_DEF
) (
    input  seq_state_e       state_i,
    input  logic             sample_tick_i,
    input  logic             host_req_i,
    input  logic [DAW-1:0]   host_addr_i,
    input  logic [DWW-1:0]   host_data_i,
    input  logic [DAW-1:0]   u_addrW_i,
    input  logic [DWW-1:0]   u_dataW_i,
    input  logic             u_we_i,
    output logic             host_gnt_o,
    output logic [DAW-1:0]   mem_addrW_o,
    output logic [DWW-1:0]   mem_dataW_o,
    output logic             mem_we_o
);

    always_comb begin
        host_gnt_o  = 1'b0;
        mem_addrW_o = u_addrW_i;
        mem_dataW_o = u_dataW_i;
        mem_we_o    = 1'b0;
        if (state_i == IDLE) begin
            host_gnt_o  = host_req_i & ~sample_tick_i;
            mem_addrW_o = host_addr_i;
            mem_dataW_o = host_data_i;
            mem_we_o    = host_req_i & ~sample_tick_i;
        end else begin
            mem_we_o    = u_we_i;
        end
    end

endmodule

// File: rtl/udsp_frame_sequencer.sv
// Per-frame uDSP controller: start pulse, run/drain timing, overrun tracking, RAM write-port ownership.
// Define UDSP_SEQ_OVR_COUNT_EN to add the saturating ovr_count_o overrun counter.
module udsp_frame_sequencer
    import udsp_pkg::*;
#(
    parameter int DAW       = DAW_DEF,
    parameter int DWW       = DWW_DEF,
    parameter int IAW       = IAW_DEF,
    parameter int DRAIN_CYC = UDSP_DRAIN_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick_i,
    input  logic [IAW-1:0]   prog_len_i,
    output logic             udsp_start_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             overrun_o,
    input  logic             ovr_clr_i,
    input  logic             host_req_i,
    input  logic [DAW-1:0]   host_addr_i,
    input  logic [DWW-1:0]   host_data_i,
    output logic             host_gnt_o,
    input  logic [DAW-1:0]   u_addrW_i,
    input  logic [DWW-1:0]   u_dataW_i,
    input  logic             u_we_i,
    output logic [DAW-1:0]   mem_addrW_o,
    output logic [DWW-1:0]   mem_dataW_o,
`ifdef UDSP_SEQ_OVR_COUNT_EN
    output logic [15:0]      ovr_count_o,
`endif
    output logic             mem_we_o
);

    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    seq_state_e     state_q, state_d;
    logic [IAW-1:0] cnt_q, cnt_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           start_q, busy_q, done_q, ovr_q;
    logic           ovr_set;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE: begin
                if (sample_tick_i) begin
                    state_d = START;
                    // Holds len-1 through START; a zero length runs as one instruction.
                    cnt_d   = (prog_len_i == '0) ? '0 : prog_len_i - 1'b1;
                end
            end
            START: state_d = RUN;
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                    dcnt_d  = DCW'(DRAIN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ovr_set = sample_tick_i & (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            start_q <= (state_d == START);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == DRAIN) && (dcnt_q == '0);
            ovr_q   <= ovr_set | (ovr_q & ~ovr_clr_i);
        end
    end

`ifdef UDSP_SEQ_OVR_COUNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (ovr_set) begin
            if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
        end else if (ovr_clr_i) begin
            ovr_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovr_cnt_q <= '0;
        else       ovr_cnt_q <= ovr_cnt_d;
    end

    assign ovr_count_o = ovr_cnt_q;
`endif

    assign udsp_start_o = start_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign overrun_o    = ovr_q;

    udsp_wport_mux #(
        .DAW (DAW),
        .DWW (DWW)
    ) u_wport_mux (
        .state_i       (state_q),
        .sample_tick_i (sample_tick_i),
        .host_req_i    (host_req_i),
        .host_addr_i   (host_addr_i),
        .host_data_i   (host_data_i),
        .u_addrW_i     (u_addrW_i),
        .u_dataW_i     (u_dataW_i),
        .u_we_i        (u_we_i),
        .host_gnt_o    (host_gnt_o),
        .mem_addrW_o   (mem_addrW_o),
        .mem_dataW_o   (mem_dataW_o),
        .mem_we_o      (mem_we_o)
    );

endmodule

// File: tb/tb_udsp_frame_sequencer.sv
// Bench for udsp_frame_sequencer: directed frames plus random traffic against a frame-window model.
module tb_udsp_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [8:0]  plen = '0;
    logic        oclr = 1'b0;
    logic        hreq = 1'b0;
    logic [9:0]  haddr = '0;
    logic [35:0] hdata = '0;
    logic [9:0]  uaddr = '0;
    logic [35:0] udata = '0;
    logic        uwe = 1'b0;

    logic        udsp_start, busy, frame_done, overrun, host_gnt, mem_we;
    logic [9:0]  mem_addr;
    logic [35:0] mem_data;
`ifdef UDSP_SEQ_OVR_COUNT_EN
    logic [15:0] ovr_count;
`endif

    udsp_frame_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick_i (tick),
        .prog_len_i    (plen),
        .udsp_start_o  (udsp_start),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .overrun_o     (overrun),
        .ovr_clr_i     (oclr),
        .host_req_i    (hreq),
        .host_addr_i   (haddr),
        .host_data_i   (hdata),
        .host_gnt_o    (host_gnt),
        .u_addrW_i     (uaddr),
        .u_dataW_i     (udata),
        .u_we_i        (uwe),
        .mem_addrW_o   (mem_addr),
        .mem_dataW_o   (mem_data),
`ifdef UDSP_SEQ_OVR_COUNT_EN
        .ovr_count_o   (ovr_count),
`endif
        .mem_we_o      (mem_we)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: an accepted tick at cycle t with length L makes cycles t+1..t+L+4 busy,
    // pulses start at t+1 and frame_done at t+L+5.
    int f_t = 0, f_L = 0, done_at = -1;
    bit f_valid = 0;
    bit ovr_e = 0;
    int ocnt_e = 0;
    bit last_ge = 0;

    int obs_start, obs_done, obs_gnt, busy_n, start_n, gnt_n;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic clear_obs();
        obs_start = -1; obs_done = -1; obs_gnt = -1;
        busy_n = 0; start_n = 0; gnt_n = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick = 1'b0; hreq = 1'b0; uwe = 1'b0; oclr = 1'b0;
        #1;
        chk("rst_start", udsp_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_gnt", host_gnt, 0);
        chk("rst_we", mem_we, 0);
`ifdef UDSP_SEQ_OVR_COUNT_EN
        chk("rst_ocnt", ovr_count, 0);
`endif
        @(posedge clk); cyc++;
        #1 reset = 1'b0;
        f_valid = 0; done_at = -1; ovr_e = 0; ocnt_e = 0;
    endtask

    task automatic do_cycle(input bit t, input int pl, input bit hr, input bit cl);
        bit be, se, de, ge;
        logic [63:0] r;
        @(posedge clk); cyc++;
        #1;
        r = {$urandom, $urandom};
        tick = t; plen = pl[8:0]; hreq = hr; oclr = cl;
        uaddr = r[45:36]; udata = r[35:0]; uwe = r[63];
        #2;
        be = f_valid && (cyc >= f_t + 1) && (cyc <= f_t + f_L + 4);
        se = f_valid && (cyc == f_t + 1);
        de = (cyc == done_at);
        ge = !be && hr && !t;
        last_ge = ge;
        chk("udsp_start", udsp_start, se);
        chk("busy", busy, be);
        chk("frame_done", frame_done, de);
        chk("overrun", overrun, ovr_e);
        chk("host_gnt", host_gnt, ge);
        chk("mem_we", mem_we, be ? uwe : ge);
        if (be) begin
            chk("mem_addr_u", mem_addr, uaddr);
            chk("mem_data_u", mem_data, udata);
        end else if (ge) begin
            chk("mem_addr_h", mem_addr, haddr);
            chk("mem_data_h", mem_data, hdata);
        end
`ifdef UDSP_SEQ_OVR_COUNT_EN
        chk("ovr_count", ovr_count, ocnt_e);
`endif
        if (udsp_start) begin obs_start = cyc; start_n++; end
        if (frame_done) obs_done = cyc;
        if (busy) busy_n++;
        if (host_gnt) begin obs_gnt = cyc; gnt_n++; end
        if (t && be) begin
            ovr_e = 1;
            if (ocnt_e < 65535) ocnt_e++;
        end else if (cl) begin
            ovr_e = 0;
            ocnt_e = 0;
        end
        if (t && !be) begin
            f_t = cyc; f_L = (pl == 0) ? 1 : pl; f_valid = 1;
            done_at = cyc + f_L + 5;
        end
    endtask

    initial begin
        int t0;
        bit granted;
        apply_reset();
        repeat (4) do_cycle(0, 0, 0, 0);

        // prog_len=5: start one cycle after tick, 9 busy cycles, done 10 after tick
        clear_obs();
        do_cycle(1, 5, 0, 0); t0 = cyc;
        repeat (12) do_cycle(0, 5, 0, 0);
        chk("len5_start_lat", obs_start - t0, 1);
        chk("len5_done_lat", obs_done - t0, 10);
        chk("len5_busy_cycles", busy_n, 9);

        // prog_len=0 runs as length 1
        clear_obs();
        do_cycle(1, 0, 0, 0); t0 = cyc;
        repeat (8) do_cycle(0, 0, 0, 0);
        chk("len0_done_lat", obs_done - t0, 6);
        chk("len0_busy_cycles", busy_n, 5);

        // host write held through RUN: exactly one grant in the frame_done cycle
        clear_obs();
        haddr = 10'h012; hdata = 36'h123456789;
        do_cycle(1, 7, 0, 0); t0 = cyc;
        granted = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(0, 7, !granted, 0);
            if (last_ge) granted = 1;
        end
        chk("host_run_grants", gnt_n, 1);
        chk("host_run_gnt_cyc", obs_gnt - t0, 12);

        // tick and host_req together in IDLE: tick wins, host granted after frame_done
        clear_obs();
        haddr = 10'h3A5; hdata = 36'hF0F0A5A5C;
        do_cycle(1, 2, 1, 0); t0 = cyc;
        granted = 0;
        for (int i = 0; i < 12; i++) begin
            do_cycle(0, 2, !granted, 0);
            if (last_ge) granted = 1;
        end
        chk("tick_prio_grants", gnt_n, 1);
        chk("tick_prio_gnt_cyc", obs_gnt - t0, 7);

        // second tick mid-RUN: overrun, no extra start; then clear
        clear_obs();
        do_cycle(1, 20, 0, 0); t0 = cyc;
        repeat (5) do_cycle(0, 20, 0, 0);
        do_cycle(1, 20, 0, 0);
        repeat (22) do_cycle(0, 20, 0, 0);
        chk("ovr_single_start", start_n, 1);
        chk("ovr_flag_set", overrun, 1);
`ifdef UDSP_SEQ_OVR_COUNT_EN
        chk("ovr_count_one", ovr_count, 1);
`endif
        do_cycle(0, 0, 0, 1);
        do_cycle(0, 0, 0, 0);
        chk("ovr_flag_clr", overrun, 0);

        // reset during DRAIN, then a clean frame
        clear_obs();
        do_cycle(1, 3, 0, 0); t0 = cyc;
        repeat (5) do_cycle(0, 3, 0, 0);
        chk("pre_rst_busy", busy, 1);
        apply_reset();
        clear_obs();
        repeat (8) do_cycle(0, 3, 0, 0);
        chk("no_done_after_rst", obs_done, -1);
        do_cycle(1, 4, 0, 0); t0 = cyc;
        repeat (11) do_cycle(0, 4, 0, 0);
        chk("post_rst_done_lat", obs_done - t0, 9);

        // random traffic
        haddr = 10'h155; hdata = 36'h987654321;
        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom % 12) == 0, $urandom_range(12, 0),
                     ($urandom % 3) == 0, ($urandom % 20) == 0);
        end

`ifdef UDSP_SEQ_OVR_COUNT_EN
        do_cycle(0, 0, 0, 1);
        repeat (70500) do_cycle(1, 511, 0, 0);
        chk("ovr_count_sat", ovr_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
